// File: rtl/alu_arbiter.sv
// alu_arbiter -- two-requester add/subtract unit with a single shared adder.
//
// A requester raises reqN with its operands; in IDLE one requester is granted
// (ackN pulses combinationally in that cycle and its operands are captured at
// the edge). EXEC computes and registers the result, RESP presents it until
// the consumer accepts it, then the unit returns to IDLE.
//
// Handshake: reqN/ackN is a capture strobe -- the operands of requester N are
// taken at the rising edge in which ackN is high. rsp_valid/rsp_ready: a
// response transfers at the rising edge in which both are high; while
// rsp_valid is high the rsp_* outputs hold steady, and rsp_ready has no
// effect while rsp_valid is low.
//
// Configuration macro: ALU_ARB_RR_EN
//   defined   -> round-robin arbitration with a 1-bit favoured-requester pointer
//   undefined -> fixed priority, requester 0 always wins
//
// Ports:
//   clk, resetn              clock, synchronous active-low reset
//   req0/req1                operation pending per requester
//   x0,y0,x1,y1 [WIDTH]      two's-complement operands
//   add_sub0/add_sub1        0 = x+y, 1 = x-y
//   ack0/ack1                operand-capture strobe
//   rsp_valid/rsp_ready      response handshake
//   rsp_id                   requester the response belongs to
//   rsp_s [WIDTH]            result
//   rsp_overflow/negative/zero/cout   result flags
//   o_dbg_state [2]          current FSM state (0 IDLE, 1 EXEC, 2 RESP)

module alu_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] x0,
  input  logic [WIDTH-1:0] y0,
  input  logic [WIDTH-1:0] x1,
  input  logic [WIDTH-1:0] y1,
  input  logic             add_sub0,
  input  logic             add_sub1,
  output logic             ack0,
  output logic             ack1,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_s,
  output logic             rsp_overflow,
  output logic             rsp_negative,
  output logic             rsp_zero,
  output logic             rsp_cout,
  output logic [1:0]       o_dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic w_gnt0;
  logic w_gnt1;

  // Captured operation
  logic [WIDTH-1:0] r_x;
  logic [WIDTH-1:0] r_y;
  logic             r_sub;
  logic             r_id;

  // Registered response
  logic             r_rsp_id;
  logic [WIDTH-1:0] r_rsp_s;
  logic             r_rsp_ovf;
  logic             r_rsp_neg;
  logic             r_rsp_zero;
  logic             r_rsp_cout;

  logic [WIDTH-1:0] w_y_eff;
  logic [WIDTH:0]   w_sum;
  logic             w_ovf;

`ifdef ALU_ARB_RR_EN
  // r_ptr names the requester that wins a tie; after a grant the other
  // requester becomes favoured.
  logic r_ptr;

  assign w_gnt0 = req0 & (~req1 | ~r_ptr);
  assign w_gnt1 = req1 & ~w_gnt0;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_ptr <= 1'b0;
    end else if (ack0 | ack1) begin
      r_ptr <= ack0;
    end
  end
`else
  assign w_gnt0 = req0;
  assign w_gnt1 = req1 & ~req0;
`endif

  // Next state and strobes. Acks and rsp_valid are gated by resetn so that
  // nothing is granted or delivered while the unit is being reset.
  always_comb begin
    w_state_nxt = r_state;
    ack0        = 1'b0;
    ack1        = 1'b0;
    rsp_valid   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (resetn) begin
          ack0 = w_gnt0;
          ack1 = w_gnt1;
        end
        if (w_gnt0 | w_gnt1) begin
          w_state_nxt = ST_EXEC;
        end
      end
      ST_EXEC: begin
        w_state_nxt = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid = resetn;
        if (rsp_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Operand capture on the grant edge
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_x   <= '0;
      r_y   <= '0;
      r_sub <= 1'b0;
      r_id  <= 1'b0;
    end else if (ack0) begin
      r_x   <= x0;
      r_y   <= y0;
      r_sub <= add_sub0;
      r_id  <= 1'b0;
    end else if (ack1) begin
      r_x   <= x1;
      r_y   <= y1;
      r_sub <= add_sub1;
      r_id  <= 1'b1;
    end
  end

  // Subtraction is x + ~y + 1, so the carry-in is the op bit itself.
  assign w_y_eff = r_sub ? ~r_y : r_y;
  assign w_sum   = {1'b0, r_x} + {1'b0, w_y_eff} + {{WIDTH{1'b0}}, r_sub};
  assign w_ovf   = (r_x[WIDTH-1] == w_y_eff[WIDTH-1]) &
                   (w_sum[WIDTH-1] != r_x[WIDTH-1]);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_rsp_id   <= 1'b0;
      r_rsp_s    <= '0;
      r_rsp_ovf  <= 1'b0;
      r_rsp_neg  <= 1'b0;
      r_rsp_zero <= 1'b0;
      r_rsp_cout <= 1'b0;
    end else if (r_state == ST_EXEC) begin
      r_rsp_id   <= r_id;
      r_rsp_s    <= w_sum[WIDTH-1:0];
      r_rsp_ovf  <= w_ovf;
      r_rsp_neg  <= w_sum[WIDTH-1];
      r_rsp_zero <= (w_sum[WIDTH-1:0] == '0);
      r_rsp_cout <= w_sum[WIDTH];
    end
  end

  assign rsp_id       = r_rsp_id;
  assign rsp_s        = r_rsp_s;
  assign rsp_overflow = r_rsp_ovf;
  assign rsp_negative = r_rsp_neg;
  assign rsp_zero     = r_rsp_zero;
  assign rsp_cout     = r_rsp_cout;
  assign o_dbg_state  = r_state;

endmodule
